// File: rtl/eth_rx_framer_pkg.sv
// Shared constants, state type and CRC-32 byte step for the GMII receive framer.
// The CRC items are consumed only when FCS_CHECK_EN is defined.
package eth_rx_framer_pkg;

   localparam logic [7:0]  ETH_PREAMBLE_BYTE = 8'h55;
   localparam logic [7:0]  ETH_SFD_BYTE      = 8'hD5;

   localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB88320;
   localparam logic [31:0] CRC32_INIT      = 32'hFFFFFFFF;
   localparam logic [31:0] CRC32_RESIDUE   = 32'hDEBB20E3;

   typedef enum logic [1:0] {IDLE, PREAMBLE, PAYLOAD, DROP} rx_framer_state_t;

   // One byte of the reflected CRC-32, LSB of the byte first.
   function automatic logic [31:0] crc32Byte(input logic [31:0] crc, input logic [7:0] data);
      logic [31:0] c;
      c = crc ^ {24'h0, data};
      for (int i = 0; i < 8; i++) begin
         c = c[0] ? ((c >> 1) ^ CRC32_POLY_REFL) : (c >> 1);
      end
      return c;
   endfunction

endpackage

// File: rtl/eth_crc32_d8.sv
// Registered CRC-32, one byte per cycle; initIn has priority over enIn.
// Built only when FCS_CHECK_EN is defined.
`ifdef FCS_CHECK_EN
module eth_crc32_d8
   import eth_rx_framer_pkg::*;
(
   input  logic        clkIn,
   input  logic        rstIn,
   input  logic        initIn,
   input  logic        enIn,
   input  logic [7:0]  dataIn,
   output logic [31:0] crcOut
);

   always_ff @(posedge clkIn or posedge rstIn) begin
      if (rstIn) begin
         crcOut <= CRC32_INIT;
      end else if (initIn) begin
         crcOut <= CRC32_INIT;
      end else if (enIn) begin
         crcOut <= crc32Byte(crcOut, dataIn);
      end
   end

endmodule
`endif

// File: rtl/eth_rx_framer.sv
// GMII rx framer: strips preamble/SFD/FCS, flags sof/eof/error per frame.
// Define FCS_CHECK_EN to add CRC-32 checking of the FCS into frameErrOut.
module eth_rx_framer
   import eth_rx_framer_pkg::*;
#(
   parameter int MIN_PREAMBLE    = 1,
   parameter int MIN_FRAME_BYTES = 64,
   parameter int MAX_FRAME_BYTES = 1522
) (
   input  logic       clkIn,
   input  logic       rstIn,
   input  logic       rxDvIn,
   input  logic       rxErIn,
   input  logic [7:0] rxDataIn,
   output logic [7:0] dataOut,
   output logic       dataValidOut,
   output logic       sofOut,
   output logic       eofOut,
   output logic       frameErrOut
);

   localparam logic [2:0]  MIN_PRE_CNT = 3'(MIN_PREAMBLE);
   localparam logic [10:0] MIN_BYTES   = 11'(MIN_FRAME_BYTES);
   localparam logic [10:0] TRUNC_CNT   = 11'(MAX_FRAME_BYTES + 1);

   rx_framer_state_t  state;
   logic [2:0]        preCnt;
   logic [10:0]       byteCnt;
   logic [10:0]       nextCnt;
   logic [3:0][7:0]   dlyLine;
   logic [2:0]        fillCnt;
   logic              sofPending;
   logic              errLatch;
   logic              crcBad;

   assign nextCnt = (byteCnt == 11'h7FF) ? byteCnt : byteCnt + 11'd1;

`ifdef FCS_CHECK_EN
   logic [31:0] crcValue;
   logic        crcInit;
   logic        crcEn;

   assign crcInit = (state == PREAMBLE) && rxDvIn && !rxErIn &&
                    (rxDataIn == ETH_SFD_BYTE) && (preCnt >= MIN_PRE_CNT);
   assign crcEn   = (state == PAYLOAD) && rxDvIn;

   eth_crc32_d8 crcInst (
      .clkIn  (clkIn),
      .rstIn  (rstIn),
      .initIn (crcInit),
      .enIn   (crcEn),
      .dataIn (rxDataIn),
      .crcOut (crcValue)
   );

   assign crcBad = (crcValue != CRC32_RESIDUE);
`else
   assign crcBad = 1'b0;
`endif

   // NOTE: all state and outputs use non-blocking assignments so every branch sees pre-edge values.
   always_ff @(posedge clkIn or posedge rstIn) begin
      if (rstIn) begin
         state        <= IDLE;
         preCnt       <= '0;
         byteCnt      <= '0;
         // NOTE: the delay line is a packed vector, so it clears in one assignment like any register.
         dlyLine      <= '0;
         fillCnt      <= '0;
         sofPending   <= 1'b0;
         errLatch     <= 1'b0;
         dataOut      <= '0;
         dataValidOut <= 1'b0;
         sofOut       <= 1'b0;
         eofOut       <= 1'b0;
         frameErrOut  <= 1'b0;
      end else begin
         dataValidOut <= 1'b0;
         sofOut       <= 1'b0;
         eofOut       <= 1'b0;
         frameErrOut  <= 1'b0;

         case (state)
            IDLE: begin
               if (rxDvIn) begin
                  if (rxDataIn == ETH_PREAMBLE_BYTE) begin
                     state  <= PREAMBLE;
                     preCnt <= 3'd1;
                  end else begin
                     state <= DROP;
                  end
               end
            end

            PREAMBLE: begin
               if (!rxDvIn) begin
                  state <= IDLE;
               end else if (rxErIn) begin
                  state <= DROP;
               end else if (rxDataIn == ETH_PREAMBLE_BYTE) begin
                  if (preCnt != 3'd7) preCnt <= preCnt + 3'd1;
               end else if ((rxDataIn == ETH_SFD_BYTE) && (preCnt >= MIN_PRE_CNT)) begin
                  state      <= PAYLOAD;
                  byteCnt    <= '0;
                  fillCnt    <= '0;
                  sofPending <= 1'b1;
                  errLatch   <= 1'b0;
               end else begin
                  state <= DROP;
               end
            end

            PAYLOAD: begin
               if (!rxDvIn) begin
                  // Whatever is left in the delay line is the FCS and is discarded.
                  eofOut      <= 1'b1;
                  frameErrOut <= errLatch || (byteCnt < MIN_BYTES) || crcBad;
                  state       <= IDLE;
               end else begin
                  byteCnt  <= nextCnt;
                  errLatch <= errLatch || rxErIn;
                  dlyLine  <= {dlyLine[2:0], rxDataIn};
                  if (nextCnt == TRUNC_CNT) begin
                     eofOut      <= 1'b1;
                     frameErrOut <= 1'b1;
                     state       <= DROP;
                  end else if (fillCnt == 3'd4) begin
                     dataOut      <= dlyLine[3];
                     dataValidOut <= 1'b1;
                     sofOut       <= sofPending;
                     sofPending   <= 1'b0;
                  end else begin
                     fillCnt <= fillCnt + 3'd1;
                  end
               end
            end

            DROP: begin
               if (!rxDvIn) state <= IDLE;
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_eth_rx_framer.sv
// Self-checking bench: frame-level model predicts every output cycle for two
// instances (MIN_PREAMBLE=1 and 3); honours FCS_CHECK_EN like the design.
module tb_eth_rx_framer;

   localparam int MINB = 64;
   localparam int MAXB = 1522;
`ifdef FCS_CHECK_EN
   localparam bit FCS_EN = 1'b1;
`else
   localparam bit FCS_EN = 1'b0;
`endif

   typedef logic [7:0] byteQ [$];
   typedef struct packed {logic rst; logic dv; logic er; logic [7:0] d;} stimT;
   typedef struct packed {logic v; logic [7:0] d; logic sof; logic eof; logic err;} outT;

   logic       clkIn = 1'b0;
   logic       rstIn = 1'b1;
   logic       rxDvIn = 1'b0;
   logic       rxErIn = 1'b0;
   logic [7:0] rxDataIn = 8'h00;

   logic [7:0] data1, data3;
   logic       dv1, sof1, eof1, err1;
   logic       dv3, sof3, eof3, err3;

   stimT stim[$];
   outT  exp1[$];
   outT  exp3[$];
   int   errors = 0;
   int   checks = 0;
   int   phaseEnd = 0;

   always #4 clkIn = ~clkIn;

   eth_rx_framer dut1 (
      .clkIn(clkIn), .rstIn(rstIn), .rxDvIn(rxDvIn), .rxErIn(rxErIn), .rxDataIn(rxDataIn),
      .dataOut(data1), .dataValidOut(dv1), .sofOut(sof1), .eofOut(eof1), .frameErrOut(err1)
   );

   eth_rx_framer #(.MIN_PREAMBLE(3)) dut3 (
      .clkIn(clkIn), .rstIn(rstIn), .rxDvIn(rxDvIn), .rxErIn(rxErIn), .rxDataIn(rxDataIn),
      .dataOut(data3), .dataValidOut(dv3), .sofOut(sof3), .eofOut(eof3), .frameErrOut(err3)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
      end
   endtask

   function automatic logic [31:0] crcOf(input byteQ b, input int n);
      logic [31:0] c = 32'hFFFFFFFF;
      for (int i = 0; i < n; i++) begin
         c = c ^ {24'h0, b[i]};
         for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
      end
      return ~c;
   endfunction

   function automatic byteQ withFcs(input byteQ p, input bit corrupt);
      byteQ b = p;
      logic [31:0] f = crcOf(p, p.size());
      if (corrupt) f[3] = ~f[3];
      for (int i = 0; i < 4; i++) b.push_back(f[8*i +: 8]);
      return b;
   endfunction

   function automatic bit fcsOk(input byteQ b);
      int m = b.size();
      if (m < 4) return 1'b0;
      return {b[m-1], b[m-2], b[m-3], b[m-4]} == crcOf(b, m - 4);
   endfunction

   function automatic byteQ counting(input int n);
      byteQ b;
      for (int i = 0; i < n; i++) b.push_back(8'(i));
      return b;
   endfunction

   function automatic byteQ randBytes(input int n);
      byteQ b;
      for (int i = 0; i < n; i++) b.push_back(8'($urandom));
      return b;
   endfunction

   task automatic addCycle(input logic rst, input logic dv, input logic er, input logic [7:0] d);
      stim.push_back('{rst: rst, dv: dv, er: er, d: d});
      exp1.push_back('0);
      exp3.push_back('0);
   endtask

   task automatic setOut(input int inst, input int idx, input outT val);
      if (inst == 0) exp1[idx] = val;
      else           exp3[idx] = val;
   endtask

   // nPre 0x55 bytes, SFD, body (post-SFD bytes), gap idle cycles. erIdx/preErIdx/rstIdx < 0 = unused.
   task automatic addFrame(input int nPre, input byteQ body, input int erIdx,
                           input int preErIdx, input int gap, input int rstIdx);
      int m = body.size();
      int s, minPre, lastOut, eofIdx;
      bit bad;
      for (int i = 0; i < nPre; i++) addCycle(1'b0, 1'b1, i == preErIdx, 8'h55);
      addCycle(1'b0, 1'b1, nPre == preErIdx, 8'hD5);
      s = stim.size();
      for (int j = 0; j < m; j++)
         addCycle(rstIdx >= 0 && (j == rstIdx || j == rstIdx + 1), 1'b1, j == erIdx, body[j]);
      for (int g = 0; g < gap; g++) addCycle(1'b0, 1'b0, 1'b0, 8'h00);
      for (int inst = 0; inst < 2; inst++) begin
         minPre = (inst == 0) ? 1 : 3;
         if (nPre >= minPre && preErIdx < 0) begin
            if (m > MAXB) bad = 1'b1;
            else bad = (erIdx >= 0 && erIdx < m) || (m < MINB) || (FCS_EN && !fcsOk(body));
            lastOut = (m > MAXB) ? MAXB - 1 : m - 1;
            for (int j = 4; j <= lastOut; j++)
               setOut(inst, s + j, '{v: 1'b1, d: body[j-4], sof: j == 4, eof: 1'b0, err: 1'b0});
            eofIdx = (m > MAXB) ? s + MAXB : s + m;
            setOut(inst, eofIdx, '{v: 1'b0, d: 8'h00, sof: 1'b0, eof: 1'b1, err: bad});
            if (rstIdx >= 0)
               for (int k = s + rstIdx; k < stim.size(); k++) setOut(inst, k, '0);
         end
      end
   endtask

   task automatic cmpOut(input string who, input int t, input outT e, input logic v,
                         input logic [7:0] d, input logic sof, input logic eof, input logic err);
      check($sformatf("%s valid @%0d", who, t), v, e.v);
      if (e.v) check($sformatf("%s data @%0d", who, t), d, e.d);
      check($sformatf("%s sof @%0d", who, t), sof, e.sof);
      check($sformatf("%s eof @%0d", who, t), eof, e.eof);
      if (e.eof) check($sformatf("%s frameErr @%0d", who, t), err, e.err);
   endtask

   initial begin
      int dvCnt1 = 0, eofCnt1 = 0, errCnt1 = 0, dvCnt3 = 0, eofCnt3 = 0;
      int mDv1 = 0, mEof1 = 0, mDv3 = 0, firstSof = -1;
      byteQ c60 = counting(60);
      byteQ body;
      int r, nPre, preEr, erIdx;

      for (int i = 0; i < 3; i++) addCycle(1'b1, 1'b0, 1'b0, 8'h00);
      for (int i = 0; i < 2; i++) addCycle(1'b0, 1'b0, 1'b0, 8'h00);

      addFrame(7, withFcs(c60, 1'b0), -1, -1, 3, -1);
      addFrame(7, withFcs(c60, 1'b1), -1, -1, 3, -1);
      addFrame(2, counting(20), -1, -1, 3, -1);
      addFrame(7, withFcs(c60, 1'b0), 10, -1, 3, -1);
      addFrame(7, withFcs(c60, 1'b0), -1, -1, 1, -1);
      addFrame(7, withFcs(c60, 1'b0), -1, -1, 3, -1);
      addFrame(7, withFcs(c60, 1'b0), -1, -1, 3, 30);
      addFrame(7, withFcs(c60, 1'b0), -1, -1, 3, -1);
      phaseEnd = stim.size();

      // Model pins: hand-computed totals for the directed frames above.
      for (int t = 0; t < phaseEnd; t++) begin
         mDv1 += exp1[t].v;  mEof1 += exp1[t].eof;  mDv3 += exp3[t].v;
         if (firstSof < 0 && exp1[t].sof) firstSof = t;
      end
      check("model dut1 data count", mDv1, 402);
      check("model dut1 eof count", mEof1, 7);
      check("model dut3 data count", mDv3, 386);
      check("model first sof byte", exp1[firstSof].d, 8'h00);

      // Length boundaries around runt, empty and truncation limits.
      addFrame(3, withFcs(counting(59), 1'b0), -1, -1, 2, -1);
      addFrame(3, withFcs(counting(60), 1'b0), -1, -1, 2, -1);
      addFrame(3, withFcs(counting(0), 1'b0), -1, -1, 2, -1);
      addFrame(3, counting(5), -1, -1, 2, -1);
      addFrame(3, counting(0), -1, -1, 2, -1);
      addFrame(3, withFcs(randBytes(1518), 1'b0), -1, -1, 2, -1);
      addFrame(3, randBytes(1523), -1, -1, 2, -1);
      addFrame(5, randBytes(1530), -1, -1, 1, -1);

      for (int f = 0; f < 60; f++) begin
         r = $urandom_range(0, 9);
         if (r == 0) begin
            for (int i = 0; i < int'($urandom_range(1, 10)); i++) begin
               logic [7:0] d = 8'($urandom);
               if (i == 0 && d == 8'h55) d = 8'h00;
               addCycle(1'b0, 1'b1, 1'b0, d);
            end
            addCycle(1'b0, 1'b0, 1'b0, 8'h00);
         end else begin
            nPre  = $urandom_range(0, 8);
            body  = (r == 1) ? randBytes($urandom_range(0, 6))
                             : withFcs(randBytes($urandom_range(0, 80)), $urandom_range(0, 4) == 0);
            preEr = (nPre > 0 && $urandom_range(0, 9) == 0) ? int'($urandom_range(1, nPre)) : -1;
            erIdx = (body.size() > 0 && $urandom_range(0, 6) == 0)
                    ? int'($urandom_range(0, body.size() - 1)) : -1;
            addFrame(nPre, body, erIdx, preEr, $urandom_range(1, 4), -1);
         end
      end

      fork
         begin : driver
            for (int t = 0; t < stim.size(); t++) begin
               @(negedge clkIn);
               rstIn    = stim[t].rst;
               rxDvIn   = stim[t].dv;
               rxErIn   = stim[t].er;
               rxDataIn = stim[t].d;
               if (t > 0 && stim[t].rst && !stim[t-1].rst) begin
                  #1;
                  check("async reset clears dataValidOut", dv1, 1'b0);
                  check("async reset clears eofOut", eof1, 1'b0);
                  check("async reset clears sofOut", sof1, 1'b0);
               end
            end
         end
         begin : compare
            @(negedge clkIn);
            for (int t = 0; t < stim.size(); t++) begin
               @(posedge clkIn);
               #2;
               cmpOut("dut1", t, exp1[t], dv1, data1, sof1, eof1, err1);
               cmpOut("dut3", t, exp3[t], dv3, data3, sof3, eof3, err3);
               check($sformatf("dut1 eof with data @%0d", t), dv1 && eof1, 1'b0);
               if (t < phaseEnd) begin
                  dvCnt1 += dv1;  eofCnt1 += eof1;  errCnt1 += (eof1 && err1);
                  dvCnt3 += dv3;  eofCnt3 += eof3;
               end
            end
         end
      join

      check("dut1 directed data count", dvCnt1, 402);
      check("dut1 directed eof count", eofCnt1, 7);
      check("dut1 directed bad frames", errCnt1, FCS_EN ? 3 : 2);
      check("dut3 directed data count", dvCnt3, 386);
      check("dut3 directed eof count", eofCnt3, 6);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/eth_rx_framer.md
Name: eth_rx_framer

Overview:
- Receive-side GMII byte framer in the 125 MHz PHY rx clock domain.
- Sits directly upstream of the slow-to-fast CDC. Its dataOut/dataValidOut drive the CDC's wrDataIn/wrEnIn.
- Strips preamble, SFD and 4-byte FCS, so only frame payload bytes (DA through end of payload) cross into the 250 MHz domain.
- Flags start, end and error per frame.

Parameters:
- MIN_PREAMBLE, 1: minimum count of 0x55 bytes before SFD for a start to be accepted (range 1..7).
- MIN_FRAME_BYTES, 64: minimum post-SFD byte count, FCS included; shorter frames are flagged as runts.
- MAX_FRAME_BYTES, 1522: maximum post-SFD byte count, FCS included; longer frames are truncated and flagged.

Ports:
- clkIn  in  1  PHY rx clock, 125 MHz.
- rstIn  in  1  reset, asynchronous, active-high.
- rxDvIn  in  1  GMII RX_DV.
- rxErIn  in  1  GMII RX_ER.
- rxDataIn  in  8  GMII RXD.
- dataOut  out  8  payload byte, registered.
- dataValidOut  out  1  dataOut qualifier; at most one byte per cycle.
- sofOut  out  1  high with the first dataValidOut of a frame.
- eofOut  out  1  one-cycle end-of-frame pulse.
- frameErrOut  out  1  qualified by eofOut: 1 = frame bad.

Behaviour:
- Reset: already decided — one clock (clkIn); reset is asynchronous and active-high (rstIn). While rstIn is high:
  - all outputs are 0, state is IDLE;
  - the delay line, byte counter, preamble counter and error latch are cleared.
- FSM states: IDLE, PREAMBLE, PAYLOAD, DROP. All inputs are sampled on the rising edge of clkIn.
- IDLE:
  - rxDvIn=1 and data=0x55 -> PREAMBLE, preCnt=1.
  - rxDvIn=1 with any other data -> DROP.
- PREAMBLE:
  - rxDvIn=0 -> IDLE, no outputs.
  - 0x55 -> preCnt+1, saturating at 7.
  - 0xD5 with preCnt>=MIN_PREAMBLE -> PAYLOAD, byteCnt=0.
  - Anything else, or rxErIn=1 -> DROP.
- PAYLOAD:
  - Each rxDvIn=1 byte increments byteCnt (11-bit, saturating) and shifts into a 4-entry delay line.
  - When the delay line already holds 4 bytes, the oldest byte is registered to dataOut with dataValidOut=1 in the next cycle.
  - Latency: payload byte k appears one cycle after the edge that samples post-SFD byte k+4. FCS bytes are never output.
  - rxErIn=1 sets the error latch.
  - byteCnt reaching MAX_FRAME_BYTES+1 -> eofOut=1, frameErrOut=1, -> DROP.
  - rxDvIn=0 -> eofOut pulse next cycle and -> IDLE. The delay-line contents (the FCS) are discarded.
  - At eofOut, frameErrOut = error latch OR byteCnt<MIN_FRAME_BYTES (OR the CRC fail when enabled).
- DROP: no outputs; remains until rxDvIn=0 is sampled, then -> IDLE.
- sofOut: asserted only on the first dataValidOut after SFD. A frame with <=4 post-SFD bytes produces eofOut with frameErrOut=1 and no sofOut and no data.
- eofOut: never coincides with dataValidOut. It pulses only for frames that reached PAYLOAD.
- Back-to-back frames: a single rxDvIn=0 cycle between frames is sufficient. IDLE accepts 0x55 on the cycle after eofOut's trigger.
- Reset mid-frame: everything clears. After release, traffic still in flight goes to DROP, or to PREAMBLE then DROP, and produces no output until rxDvIn deasserts.

Optional Feature:
- Macro: FCS_CHECK_EN.
- Defined:
  - Reflected CRC-32 (poly 0xEDB88320, init 0xFFFFFFFF) is updated over every post-SFD byte, FCS included.
  - At eofOut, a register value other than residue 0xDEBB20E3 ORs into frameErrOut.
  - The CRC is re-initialised on SFD.
- Undefined: no CRC logic is built; FCS is stripped unchecked and frameErrOut ignores FCS.

Decomposition:
- Shared package pkg:
  - ETH_PREAMBLE_BYTE=8'h55, ETH_SFD_BYTE=8'hD5;
  - CRC32_POLY_REFL, CRC32_INIT, CRC32_RESIDUE;
  - typedef enum rx_framer_state_t {IDLE, PREAMBLE, PAYLOAD, DROP}.
- Sub-module eth_crc32_d8: 8-bit-per-cycle registered CRC with initIn/enIn/dataIn/crcOut.
  - Instantiated only under FCS_CHECK_EN.
  - Reusable by a future tx FCS generator.

Test Plan:
- 7x0x55, 0xD5, 60 payload bytes 0x00..0x3B, valid FCS:
  - 60 dataValidOut cycles, bytes 0x00..0x3B in order; sofOut with 0x00.
  - eofOut one cycle after rxDvIn falls; frameErrOut=0.
- Same frame with one FCS bit flipped: identical data; frameErrOut=1 with FCS_CHECK_EN defined, 0 without it.
- 2x0x55, 0xD5, 20 bytes with MIN_PREAMBLE=1:
  - 16 bytes output, eofOut=1, frameErrOut=1 (runt 20<64).
  - With MIN_PREAMBLE=3: no outputs at all (DROP).
- rxErIn pulsed on payload byte 10 of a 64-byte frame: all 60 bytes are output, eofOut with frameErrOut=1.
- Two valid 64-byte frames separated by 1 idle cycle: two sofOut/eofOut pairs, 120 data bytes, no errors.
- rstIn asserted on payload byte 30, released while rxDvIn is still high:
  - outputs drop to 0 immediately, no eofOut;
  - the next clean frame is received correctly.
